// File: rtl/output_port_writer.sv
// Output port writer: buffers packet words and their forwarding decisions, pairs them in order,
// stamps the decision into the IOQ module header and forwards (or drops) each packet.
module output_port_writer #(
    parameter int          DATA_WIDTH          = 64,
    parameter int          CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int          NUM_OUTPUT_QUEUES   = 8,
    parameter logic [7:0]  IOQ_STAGE_NUM       = 8'hFF,
    parameter int          DST_PORT_POS        = 48,
    parameter int          IN_FIFO_DEPTH_BITS  = 4,
    parameter int          DEC_FIFO_DEPTH_BITS = 2,
    parameter bit          DROP_EMPTY          = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    input  logic [NUM_OUTPUT_QUEUES-1:0] dec_ports,
    input  logic                         dec_wr,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    input  logic                         clear_counters,
    output logic [31:0]                  pkt_fwd_count,
    output logic [31:0]                  pkt_drop_count,
    output logic                         overflow
);

    localparam int IAW       = IN_FIFO_DEPTH_BITS;
    localparam int DAW       = DEC_FIFO_DEPTH_BITS;
    localparam int FW        = CTRL_WIDTH + DATA_WIDTH;
    localparam int IN_DEPTH  = 1 << IAW;
    localparam int DEC_DEPTH = 1 << DAW;
    localparam logic [IAW:0] IN_FULL   = (IAW + 1)'(IN_DEPTH);
    localparam logic [IAW:0] IN_NFULL  = (IAW + 1)'(IN_DEPTH - 1);
    localparam logic [DAW:0] DEC_FULL  = (DAW + 1)'(DEC_DEPTH);
    localparam logic [DAW:0] DEC_NFULL = (DAW + 1)'(DEC_DEPTH - 1);
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL  = CTRL_WIDTH'(IOQ_STAGE_NUM);
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DROP = 2'd3
    } state_t;

    logic [FW-1:0]                in_mem [IN_DEPTH];
    logic [IAW-1:0]               in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IAW:0]                 in_cnt_q, in_cnt_d;
    logic [NUM_OUTPUT_QUEUES-1:0] dec_mem [DEC_DEPTH];
    logic [DAW-1:0]               dec_wptr_q, dec_wptr_d, dec_rptr_q, dec_rptr_d;
    logic [DAW:0]                 dec_cnt_q, dec_cnt_d;

    state_t                       state_q, state_d;
    logic [NUM_OUTPUT_QUEUES-1:0] dec_latch_q, dec_latch_d;
    logic                         drop_body_q, drop_body_d;
    logic [31:0]                  fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                         overflow_q, overflow_d;

    logic                         in_full_s, in_empty_s, in_push_s, in_pop_s;
    logic                         dec_full_s, dec_empty_s, dec_push_s, dec_pop_s;
    logic [FW-1:0]                in_head_s;
    logic [CTRL_WIDTH-1:0]        head_ctrl_s;
    logic [DATA_WIDTH-1:0]        head_data_s, out_data_s;
    logic [NUM_OUTPUT_QUEUES-1:0] dec_head_s;
    logic                         out_wr_s, fwd_inc_s, drop_inc_s;

    assign in_full_s   = (in_cnt_q == IN_FULL);
    assign in_empty_s  = (in_cnt_q == {(IAW + 1){1'b0}});
    assign dec_full_s  = (dec_cnt_q == DEC_FULL);
    assign dec_empty_s = (dec_cnt_q == {(DAW + 1){1'b0}});
    assign in_push_s   = in_wr && !in_full_s;
    assign dec_push_s  = dec_wr && !dec_full_s;
    assign in_head_s   = in_mem[in_rptr_q];
    assign head_ctrl_s = in_head_s[FW-1 -: CTRL_WIDTH];
    assign head_data_s = in_head_s[DATA_WIDTH-1:0];
    assign dec_head_s  = dec_mem[dec_rptr_q];

    // FIFO storage: plain write-port arrays, read combinationally at the head pointer
    always_ff @(posedge clk) begin
        if (in_push_s) begin
            in_mem[in_wptr_q] <= {in_ctrl, in_data};
        end
        if (dec_push_s) begin
            dec_mem[dec_wptr_q] <= dec_ports;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        in_wptr_d  = in_push_s  ? in_wptr_q  + IAW'(1) : in_wptr_q;
        in_rptr_d  = in_pop_s   ? in_rptr_q  + IAW'(1) : in_rptr_q;
        dec_wptr_d = dec_push_s ? dec_wptr_q + DAW'(1) : dec_wptr_q;
        dec_rptr_d = dec_pop_s  ? dec_rptr_q + DAW'(1) : dec_rptr_q;
        case ({in_push_s, in_pop_s})
            2'b10:   in_cnt_d = in_cnt_q + (IAW + 1)'(1);
            2'b01:   in_cnt_d = in_cnt_q - (IAW + 1)'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
        case ({dec_push_s, dec_pop_s})
            2'b10:   dec_cnt_d = dec_cnt_q + (DAW + 1)'(1);
            2'b01:   dec_cnt_d = dec_cnt_q - (DAW + 1)'(1);
            default: dec_cnt_d = dec_cnt_q;
        endcase
    end

    // Packet FSM: pair a decision with the head packet, then forward or drain it
    always_comb begin
        state_d     = state_q;
        dec_latch_d = dec_latch_q;
        drop_body_d = drop_body_q;
        in_pop_s    = 1'b0;
        dec_pop_s   = 1'b0;
        out_wr_s    = 1'b0;
        fwd_inc_s   = 1'b0;
        drop_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!in_empty_s && !dec_empty_s) begin
                    dec_pop_s   = 1'b1;
                    dec_latch_d = dec_head_s;
                    drop_body_d = 1'b0;
                    if (DROP_EMPTY && (dec_head_s == {NUM_OUTPUT_QUEUES{1'b0}})) begin
                        state_d = DROP;
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                out_wr_s = out_rdy && !in_empty_s;
                in_pop_s = out_wr_s;
                if (out_wr_s && (head_ctrl_s == CTRL_ZERO)) begin
                    state_d = BODY;
                end else begin
                    state_d = HDR;
                end
            end
            BODY: begin
                out_wr_s = out_rdy && !in_empty_s;
                in_pop_s = out_wr_s;
                if (out_wr_s && (head_ctrl_s != CTRL_ZERO)) begin
                    state_d   = IDLE;
                    fwd_inc_s = 1'b1;
                end else begin
                    state_d = BODY;
                end
            end
            DROP: begin
                in_pop_s = !in_empty_s;
                if (in_pop_s && (head_ctrl_s == CTRL_ZERO)) begin
                    drop_body_d = 1'b1;
                end else if (in_pop_s && drop_body_q) begin
                    state_d     = IDLE;
                    drop_inc_s  = 1'b1;
                    drop_body_d = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Header rewrite: only IOQ words of the header carry the destination bitmap
    always_comb begin
        out_data_s = head_data_s;
        if ((state_q == HDR) && (head_ctrl_s == IOQ_CTRL)) begin
            out_data_s[DST_PORT_POS +: NUM_OUTPUT_QUEUES] = dec_latch_q;
        end else begin
            out_data_s = head_data_s;
        end
    end

    // Saturating statistics and sticky overflow; clear wins over any event
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clear_counters) begin
            fwd_cnt_d  = 32'd0;
            drop_cnt_d = 32'd0;
            overflow_d = 1'b0;
        end else begin
            if (fwd_inc_s && (fwd_cnt_q != CNT_MAX)) begin
                fwd_cnt_d = fwd_cnt_q + 32'd1;
            end else begin
                fwd_cnt_d = fwd_cnt_q;
            end
            if (drop_inc_s && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + 32'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            overflow_d = overflow_q | (in_wr && in_full_s) | (dec_wr && dec_full_s);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wptr_q   <= {IAW{1'b0}};
            in_rptr_q   <= {IAW{1'b0}};
            in_cnt_q    <= {(IAW + 1){1'b0}};
            dec_wptr_q  <= {DAW{1'b0}};
            dec_rptr_q  <= {DAW{1'b0}};
            dec_cnt_q   <= {(DAW + 1){1'b0}};
            state_q     <= IDLE;
            dec_latch_q <= {NUM_OUTPUT_QUEUES{1'b0}};
            drop_body_q <= 1'b0;
            fwd_cnt_q   <= 32'd0;
            drop_cnt_q  <= 32'd0;
            overflow_q  <= 1'b0;
        end else begin
            in_wptr_q   <= in_wptr_d;
            in_rptr_q   <= in_rptr_d;
            in_cnt_q    <= in_cnt_d;
            dec_wptr_q  <= dec_wptr_d;
            dec_rptr_q  <= dec_rptr_d;
            dec_cnt_q   <= dec_cnt_d;
            state_q     <= state_d;
            dec_latch_q <= dec_latch_d;
            drop_body_q <= drop_body_d;
            fwd_cnt_q   <= fwd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_rdy         = (in_cnt_q < IN_NFULL) && (dec_cnt_q < DEC_NFULL);
    assign out_wr         = out_wr_s;
    assign out_data       = out_data_s;
    assign out_ctrl       = head_ctrl_s;
    assign pkt_fwd_count  = fwd_cnt_q;
    assign pkt_drop_count = drop_cnt_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_output_port_writer.sv
// Directed bench for output_port_writer: forward, drop, late decision, back-pressure,
// overflow/clear and mid-packet reset, each scenario checked inline.
module tb_output_port_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [7:0]  dec_ports;
    logic        dec_wr;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        clear_counters;
    logic [31:0] pkt_fwd_count;
    logic [31:0] pkt_drop_count;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rand_rdy = 1'b0;
    logic [71:0] got_q[$];
    logic [71:0] exp_q[$];

    output_port_writer dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .dec_ports(dec_ports), .dec_wr(dec_wr),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .clear_counters(clear_counters), .pkt_fwd_count(pkt_fwd_count),
        .pkt_drop_count(pkt_drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (out_wr) got_q.push_back({out_ctrl, out_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_rdy = ($urandom_range(0, 1) == 1);
    endtask

    task automatic wait_rdy();
        for (int c = 0; c < 1000 && !in_rdy; c++) tick();
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL in_rdy_wait: in_rdy=%b, required 1", in_rdy);
        end
    endtask

    task automatic put_word(input logic [7:0] c, input logic [63:0] d, input bit force_wr);
        if (!force_wr) wait_rdy();
        in_wr = 1'b1; in_ctrl = c; in_data = d;
        tick();
        in_wr = 1'b0;
    endtask

    task automatic put_dec(input logic [7:0] d, input bit force_wr);
        if (!force_wr) wait_rdy();
        dec_wr = 1'b1; dec_ports = d;
        tick();
        dec_wr = 1'b0;
    endtask

    // IOQ header (bits 55:48 = AD), 8 body words, EOP ctrl 01; expected words queued
    task automatic send_pkt(input int tag, input logic [7:0] dec, input bit with_dec, input bit expect_fwd);
        logic [63:0] hdr, w;
        hdr = 64'hDEAD_BEEF_CAFE_0000 | 64'(tag);
        if (with_dec) put_dec(dec, 1'b0);
        put_word(8'hFF, hdr, 1'b0);
        if (expect_fwd) exp_q.push_back({8'hFF, hdr[63:56], dec, hdr[47:0]});
        for (int i = 1; i <= 8; i++) begin
            w = 64'h55AA_33CC_0000_0000 | {16'h0000, 16'(tag), 32'(i)};
            put_word(8'h00, w, 1'b0);
            if (expect_fwd) exp_q.push_back({8'h00, w});
        end
        w = 64'hE0F0_FFFF_0000_0000 | 64'(tag);
        put_word(8'h01, w, 1'b0);
        if (expect_fwd) exp_q.push_back({8'h01, w});
    endtask

    task automatic wait_fwd(input int target);
        for (int c = 0; c < 3000 && pkt_fwd_count != 32'(target); c++) tick();
        tick();
    endtask

    task automatic wait_drop(input int target);
        for (int c = 0; c < 3000 && pkt_drop_count != 32'(target); c++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_wr = 1'b0; in_ctrl = 8'h00; in_data = 64'h0; dec_wr = 1'b0;
        dec_ports = 8'h00; out_rdy = 1'b1; clear_counters = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({out_wr, in_rdy, overflow} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_flags: out_wr/in_rdy/overflow=%b, required 010", {out_wr, in_rdy, overflow});
        end
        n_checks++;
        if ({pkt_fwd_count, pkt_drop_count} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_counters: fwd=%0d drop=%0d, required 0 0", pkt_fwd_count, pkt_drop_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        got_q.delete(); exp_q.delete();
        send_pkt(1, 8'h04, 1'b1, 1'b1);
        wait_fwd(1);
        n_checks++;
        if (pkt_fwd_count !== 32'd1) begin
            n_fail++; $display("FAIL fwd_count: got %0d, required 1", pkt_fwd_count);
        end
        n_checks++;
        if (got_q.size() !== 10) begin
            n_fail++; $display("FAIL fwd_len: got %0d words, required 10", got_q.size());
        end
        foreach (exp_q[i]) begin
            logic [71:0] g;
            g = '0;
            if (i < got_q.size()) g = got_q[i];
            n_checks++;
            if (i >= got_q.size() || g !== exp_q[i]) begin
                n_fail++; $display("FAIL fwd_word%0d: got %h, required %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_drop();
        got_q.delete(); exp_q.delete();
        send_pkt(2, 8'h00, 1'b1, 1'b0);
        wait_drop(1);
        n_checks++;
        if (pkt_drop_count !== 32'd1) begin
            n_fail++; $display("FAIL drop_count: got %0d, required 1", pkt_drop_count);
        end
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL drop_no_out: got %0d words out, required 0", got_q.size());
        end
        send_pkt(3, 8'h02, 1'b1, 1'b1);
        wait_fwd(2);
        n_checks++;
        if (got_q.size() !== 10) begin
            n_fail++; $display("FAIL after_drop_len: got %0d words, required 10", got_q.size());
        end
        foreach (exp_q[i]) begin
            logic [71:0] g;
            g = '0;
            if (i < got_q.size()) g = got_q[i];
            n_checks++;
            if (i >= got_q.size() || g !== exp_q[i]) begin
                n_fail++; $display("FAIL after_drop_word%0d: got %h, required %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_late_decision();
        got_q.delete(); exp_q.delete();
        send_pkt(4, 8'h04, 1'b0, 1'b1);
        repeat (20) tick();
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL late_hold: got %0d words before decision, required 0", got_q.size());
        end
        put_dec(8'h04, 1'b0);
        wait_fwd(3);
        n_checks++;
        if (got_q.size() !== 10) begin
            n_fail++; $display("FAIL late_len: got %0d words, required 10", got_q.size());
        end
        foreach (exp_q[i]) begin
            logic [71:0] g;
            g = '0;
            if (i < got_q.size()) g = got_q[i];
            n_checks++;
            if (i >= got_q.size() || g !== exp_q[i]) begin
                n_fail++; $display("FAIL late_word%0d: got %h, required %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete(); exp_q.delete();
        rand_rdy = 1'b1;
        send_pkt(5, 8'h01, 1'b1, 1'b1);
        send_pkt(6, 8'h10, 1'b1, 1'b1);
        send_pkt(7, 8'h40, 1'b1, 1'b1);
        wait_fwd(6);
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        n_checks++;
        if (pkt_fwd_count !== 32'd6) begin
            n_fail++; $display("FAIL b2b_count: got %0d, required 6", pkt_fwd_count);
        end
        foreach (exp_q[i]) begin
            logic [71:0] g;
            g = '0;
            if (i < got_q.size()) g = got_q[i];
            n_checks++;
            if (i >= got_q.size() || g !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_word%0d: got %h, required %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        got_q.delete(); exp_q.delete();
        put_word(8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b1);
        for (int i = 0; i < 14; i++) put_word(8'h00, 64'(i), 1'b1);
        put_word(8'h01, 64'h0000_0000_0000_00EE, 1'b1);
        n_checks++;
        if ({in_rdy, overflow} !== 2'b00) begin
            n_fail++; $display("FAIL full_flags: in_rdy/overflow=%b, required 00", {in_rdy, overflow});
        end
        put_word(8'h02, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        put_dec(8'h00, 1'b1);
        wait_drop(2);
        n_checks++;
        if ({pkt_drop_count, overflow, in_rdy} !== {32'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_drain: drop=%0d overflow=%b in_rdy=%b, required 2 1 1", pkt_drop_count, overflow, in_rdy);
        end
        n_checks++;
        if (got_q.size() !== 0) begin
            n_fail++; $display("FAIL overflow_no_out: got %0d words, required 0", got_q.size());
        end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        n_checks++;
        if ({pkt_fwd_count, pkt_drop_count, overflow} !== 65'h0) begin
            n_fail++;
            $display("FAIL clear: fwd=%0d drop=%0d overflow=%b, required 0 0 0", pkt_fwd_count, pkt_drop_count, overflow);
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        put_dec(8'h08, 1'b0);
        put_word(8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        for (int i = 0; i < 3; i++) put_word(8'h00, 64'(i + 100), 1'b0);
        repeat (3) tick();
        out_rdy = 1'b1;
        #1;
        n_checks++;
        if (out_wr !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_reset: out_wr=%b, required 1", out_wr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_wr !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outwr: out_wr=%b, required 0", out_wr);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({in_rdy, pkt_fwd_count} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL mid_after: in_rdy=%b fwd=%0d, required 1 0", in_rdy, pkt_fwd_count);
        end
        got_q.delete(); exp_q.delete();
        send_pkt(8, 8'h08, 1'b1, 1'b1);
        wait_fwd(1);
        n_checks++;
        if (got_q.size() !== 10) begin
            n_fail++; $display("FAIL mid_len: got %0d words, required 10", got_q.size());
        end
        foreach (exp_q[i]) begin
            logic [71:0] g;
            g = '0;
            if (i < got_q.size()) g = got_q[i];
            n_checks++;
            if (i >= got_q.size() || g !== exp_q[i]) begin
                n_fail++; $display("FAIL mid_word%0d: got %h, required %h", i, g, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_drop();
        test_late_decision();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
